// File: rtl/minefield_board_engine.sv
// ROWSxCOLS minefield cell memory with a sequential reveal engine; a lone hidden cell reveals in 12 cycles.
// Backpressure: reveal_rdy is low while a reveal runs, and port-1 writes are dropped during that time.
module minefield_board_engine #(
  parameter int    ROWS    = 5,
  parameter int    COLS    = 5,
  parameter int    CELL_W  = 32,
  parameter int    FLOOD   = 1,
  parameter int    QDEPTH  = ROWS*COLS,
  parameter string MEMFILE = "dataMem.mem",
  localparam int   N       = ROWS*COLS,
  localparam int   AW      = $clog2(N),
  localparam int   CW      = $clog2(N+1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wEn,
  input  logic [AW-1:0]     addr1,
  input  logic [CELL_W-1:0] dataIn,
  output logic [CELL_W-1:0] dataOut1,
  input  logic [AW-1:0]     addr2,
  output logic [CELL_W-1:0] dataOut2,
  input  logic              reveal_req,
  input  logic [AW-1:0]     reveal_id,
  output logic              reveal_rdy,
  output logic              reveal_done,
  output logic              mine_hit,
  output logic              q_overflow,
  output logic [CW-1:0]     safe_count
);
  localparam int QW  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int QCW = $clog2(QDEPTH+1);
  localparam logic [CELL_W-1:0] HIDDEN   = CELL_W'(9);
  localparam logic [CELL_W-1:0] MINE     = CELL_W'(10);
  localparam logic [CELL_W-1:0] MINE_HIT = CELL_W'(11);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_SCAN, S_WRITE, S_POP, S_DONE} state_t;

  // Returns {on_board, index} of neighbour k (NW,N,NE,W,E,SW,S,SE) of cell c.
  function automatic logic [AW:0] nb_of(input logic [AW-1:0] c, input logic [2:0] k);
    int r, col, nr, nc;
    r   = int'(c) / COLS;
    col = int'(c) % COLS;
    nr  = r + ((k < 3'd3) ? -1 : (k > 3'd4) ? 1 : 0);
    nc  = col + ((k == 3'd0 || k == 3'd3 || k == 3'd5) ? -1 :
                 (k == 3'd1 || k == 3'd6) ? 0 : 1);
    if (nr >= 0 && nr < ROWS && nc >= 0 && nc < COLS) nb_of = {1'b1, AW'(nr*COLS + nc)};
    else                                              nb_of = '0;
  endfunction

  state_t            r_state, w_next;
  logic [CELL_W-1:0] r_mem [N];
  logic [AW-1:0]     r_q   [QDEPTH];
  logic [AW-1:0]     r_cur;
  logic [2:0]        r_k;
  logic [3:0]        r_cnt;
  logic [7:0]        r_mask;
  logic              r_hit, r_first, r_ovf;
  logic [CW-1:0]     r_safe;
  logic [QW-1:0]     r_qhead, r_qtail;
  logic [QCW-1:0]    r_qcnt;

  logic [CELL_W-1:0] w_cell, w_scan_val, w_mem_wd;
  logic [AW:0]       w_scan_nb, w_push_nb;
  logic [AW-1:0]     w_mem_wa;
  logic [2:0]        w_sel;
  logic              w_mem_we, w_push, w_pop, w_last_push, w_qfull;
  logic [QW-1:0]     w_qhead_nx, w_qtail_nx;

  assign w_cell      = r_mem[r_cur];
  assign w_scan_nb   = nb_of(r_cur, r_k);
  assign w_scan_val  = r_mem[w_scan_nb[AW-1:0]];
  assign w_push_nb   = nb_of(r_cur, w_sel);
  assign w_last_push = (r_mask & ~(8'b1 << w_sel)) == 8'b0;
  assign w_qfull     = (r_qcnt == QCW'(QDEPTH));
  assign w_qhead_nx  = (r_qhead == QW'(QDEPTH-1)) ? '0 : r_qhead + QW'(1);
  assign w_qtail_nx  = (r_qtail == QW'(QDEPTH-1)) ? '0 : r_qtail + QW'(1);

  // Lowest pending candidate first, so flood pushes follow scan order.
  always_comb begin
    w_sel = '0;
    for (int i = 7; i >= 0; i--) begin
      if (r_mask[i]) w_sel = 3'(i);
    end
  end

  always_comb begin
    w_next   = r_state;
    w_mem_we = 1'b0;
    w_mem_wa = r_cur;
    w_mem_wd = dataIn;
    w_push   = 1'b0;
    w_pop    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (wEn && int'(addr1) < N) begin
          w_mem_we = 1'b1;
          w_mem_wa = addr1;
        end
        if (reveal_req) w_next = S_CHECK;
      end
      S_CHECK: begin
        if (w_cell == MINE) begin
          w_mem_we = 1'b1;
          w_mem_wd = MINE_HIT;
          w_next   = S_DONE;
        end else if (w_cell == HIDDEN) begin
          w_next = S_SCAN;
        end else begin
          w_next = (FLOOD != 0) ? S_POP : S_DONE;
        end
      end
      S_SCAN: if (r_k == 3'd7) w_next = S_WRITE;
      S_WRITE: begin
        w_mem_we = r_first;
        w_mem_wd = CELL_W'(r_cnt);
        w_push   = (FLOOD != 0) && (r_cnt == 4'd0) && (r_mask != 8'd0) && w_push_nb[AW];
        w_next   = (w_push && !w_last_push) ? S_WRITE : S_POP;
      end
      S_POP: begin
        if (r_qcnt == '0) w_next = S_DONE;
        else begin
          w_pop  = 1'b1;
          w_next = S_CHECK;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Board and queue storage are deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_wa] <= w_mem_wd;
    if (w_push && !w_qfull) r_q[r_qtail] <= w_push_nb[AW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cur   <= '0;
      r_k     <= '0;
      r_cnt   <= '0;
      r_mask  <= '0;
      r_hit   <= 1'b0;
      r_first <= 1'b0;
      r_ovf   <= 1'b0;
      r_safe  <= '0;
      r_qhead <= '0;
      r_qtail <= '0;
      r_qcnt  <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (reveal_req) begin
            r_cur <= reveal_id;
            r_hit <= 1'b0;
          end
        end
        S_CHECK: begin
          r_cnt  <= '0;
          r_k    <= '0;
          r_mask <= '0;
          if (w_cell == MINE) r_hit <= 1'b1;
        end
        S_SCAN: begin
          r_k     <= r_k + 3'd1;
          r_first <= 1'b1;
          if (w_scan_nb[AW]) begin
            if (w_scan_val == MINE || w_scan_val == MINE_HIT) r_cnt <= r_cnt + 4'd1;
            if (FLOOD != 0 && w_scan_val == HIDDEN) r_mask[r_k] <= 1'b1;
          end
        end
        S_WRITE: begin
          r_first <= 1'b0;
          if (r_first && r_safe != CW'(N)) r_safe <= r_safe + CW'(1);
          if (w_push) begin
            r_mask[w_sel] <= 1'b0;
            if (w_qfull) r_ovf <= 1'b1;
            else begin
              r_qtail <= w_qtail_nx;
              r_qcnt  <= r_qcnt + QCW'(1);
            end
          end
        end
        S_POP: begin
          if (w_pop) begin
            r_cur   <= r_q[r_qhead];
            r_qhead <= w_qhead_nx;
            r_qcnt  <= r_qcnt - QCW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign dataOut1    = (int'(addr1) < N) ? r_mem[addr1] : '0;
  assign dataOut2    = (int'(addr2) < N) ? r_mem[addr2] : '0;
  assign reveal_rdy  = (r_state == S_IDLE);
  assign reveal_done = (r_state == S_DONE);
  assign mine_hit    = (r_state == S_DONE) && r_hit;
  assign q_overflow  = r_ovf;
  assign safe_count  = r_safe;
endmodule

// File: tb/tb_minefield_board_engine.sv
// Bench for minefield_board_engine: three 5x5 boards (no flood, flood with a deep queue, flood with a 2-entry queue).
// Expected reveal outcomes are queued when a request is issued and checked when reveal_done appears.
module tb_minefield_board_engine;
  localparam int N = 25;

  typedef struct {
    logic hit;
    int   safe;
    int   lat;
  } exp_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        wEn         [3];
  logic [4:0]  addr1       [3];
  logic [31:0] dataIn      [3];
  logic [31:0] dataOut1    [3];
  logic [4:0]  addr2       [3];
  logic [31:0] dataOut2    [3];
  logic        reveal_req  [3];
  logic [4:0]  reveal_id   [3];
  logic        reveal_rdy  [3];
  logic        reveal_done [3];
  logic        mine_hit    [3];
  logic        q_overflow  [3];
  logic [4:0]  safe_count  [3];

  logic [31:0] board [3][N];
  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  // Board 1 queue (80) exceeds the 72 adjacent cell pairs, so a full flood can never drop a push.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    minefield_board_engine #(
      .ROWS(5), .COLS(5), .CELL_W(32),
      .FLOOD(g == 0 ? 0 : 1),
      .QDEPTH(g == 1 ? 80 : (g == 2 ? 2 : 25)),
      .MEMFILE("")
    ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .wEn(wEn[g]), .addr1(addr1[g]), .dataIn(dataIn[g]), .dataOut1(dataOut1[g]),
      .addr2(addr2[g]), .dataOut2(dataOut2[g]),
      .reveal_req(reveal_req[g]), .reveal_id(reveal_id[g]), .reveal_rdy(reveal_rdy[g]),
      .reveal_done(reveal_done[g]), .mine_hit(mine_hit[g]), .q_overflow(q_overflow[g]),
      .safe_count(safe_count[g])
    );
  end

  function automatic int mines_around(input int d, input int c);
    int n = 0;
    int r = c / 5;
    int col = c % 5;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        int nr, nc;
        nr = r + dr;
        nc = col + dc;
        if ((dr != 0 || dc != 0) && nr >= 0 && nr < 5 && nc >= 0 && nc < 5) begin
          if (board[d][nr*5+nc] == 32'd10 || board[d][nr*5+nc] == 32'd11) n++;
        end
      end
    end
    return n;
  endfunction

  task automatic fill_board(input int d);
    for (int c = 0; c < N; c++) begin
      @(negedge clk);
      wEn[d] = 1'b1;
      addr1[d] = 5'(c);
      dataIn[d] = board[d][c];
    end
    @(negedge clk);
    wEn[d] = 1'b0;
  endtask

  task automatic issue(input int d, input int id, input logic hit, input int safe, input int lat, input bit push);
    exp_t e;
    @(negedge clk);
    total++;
    if (reveal_rdy[d] !== 1'b1) begin
      bad++;
      $display("FAIL rdy_before_issue dut%0d: got %b want 1", d, reveal_rdy[d]);
    end
    reveal_req[d] = 1'b1;
    reveal_id[d] = 5'(id);
    e.hit = hit; e.safe = safe; e.lat = lat;
    if (push) sb.push_back(e);
    @(negedge clk);
    reveal_req[d] = 1'b0;
  endtask

  // Called one negedge after the accept edge; lat counts clock cycles since that edge.
  task automatic wait_done(input int d);
    exp_t e;
    int   lat = 1;
    bit   seen = 0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      if (reveal_done[d] === 1'b1) seen = 1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    e.hit = 1'b0; e.safe = -1; e.lat = 0;
    if (sb.size() > 0) e = sb.pop_front();
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL done_timeout dut%0d: no reveal_done within 3000 cycles", d);
      return;
    end
    if (e.lat != 0) begin
      total++;
      if (lat != e.lat) begin
        bad++;
        $display("FAIL done_latency dut%0d: got %0d want %0d", d, lat, e.lat);
      end
    end
    total++;
    if (mine_hit[d] !== e.hit) begin
      bad++;
      $display("FAIL mine_hit dut%0d: got %b want %b", d, mine_hit[d], e.hit);
    end
    if (e.safe >= 0) begin
      total++;
      if (safe_count[d] !== 5'(e.safe)) begin
        bad++;
        $display("FAIL safe_count dut%0d: got %0d want %0d", d, safe_count[d], e.safe);
      end
    end
    @(negedge clk);
    total++;
    if (reveal_done[d] !== 1'b0 || mine_hit[d] !== 1'b0 || reveal_rdy[d] !== 1'b1) begin
      bad++;
      $display("FAIL done_pulse dut%0d: done=%b hit=%b rdy=%b want 0 0 1", d, reveal_done[d], mine_hit[d], reveal_rdy[d]);
    end
  endtask

  task automatic check_cell(input int d, input int c, input logic [31:0] exp, input string nm);
    addr2[d] = 5'(c);
    #1;
    total++;
    if (dataOut2[d] !== exp) begin
      bad++;
      $display("FAIL %s dut%0d cell %0d: got %0d want %0d", nm, d, c, dataOut2[d], exp);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      total++;
      if (reveal_rdy[d] !== 1'b1 || reveal_done[d] !== 1'b0 || mine_hit[d] !== 1'b0 ||
          q_overflow[d] !== 1'b0 || safe_count[d] !== 5'd0) begin
        bad++;
        $display("FAIL reset_state dut%0d: rdy=%b done=%b hit=%b ovf=%b safe=%0d want 1 0 0 0 0",
                 d, reveal_rdy[d], reveal_done[d], mine_hit[d], q_overflow[d], safe_count[d]);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_reveal();
    for (int c = 0; c < N; c++) board[0][c] = 32'd9;
    board[0][6] = 32'd10;
    fill_board(0);
    issue(0, 0, 1'b0, 1, 12, 1);
    wait_done(0);
    board[0][0] = 32'(mines_around(0, 0));
    check_cell(0, 0, board[0][0], "single_count");
    check_cell(0, 1, 32'd9, "neighbour_untouched");
    addr1[0] = 5'd0;
    #1;
    total++;
    if (dataOut1[0] !== board[0][0]) begin
      bad++;
      $display("FAIL port1_read: got %0d want %0d", dataOut1[0], board[0][0]);
    end
  endtask

  task automatic test_mine_hit();
    issue(0, 6, 1'b1, 1, 2, 1);
    wait_done(0);
    board[0][6] = 32'd11;
    check_cell(0, 6, board[0][6], "mine_marked_hit");
  endtask

  task automatic test_already_revealed();
    issue(0, 0, 1'b0, 1, 2, 1);
    wait_done(0);
    check_cell(0, 0, board[0][0], "revealed_unchanged");
  endtask

  task automatic test_edge_wrap();
    for (int c = 0; c < N; c++) board[0][c] = 32'd9;
    board[0][4] = 32'd10;
    board[0][5] = 32'd10;
    fill_board(0);
    issue(0, 9, 1'b0, 2, 12, 1);
    wait_done(0);
    board[0][9] = 32'(mines_around(0, 9));
    check_cell(0, 9, board[0][9], "right_edge_no_wrap");
    issue(0, 0, 1'b0, 3, 12, 1);
    wait_done(0);
    board[0][0] = 32'(mines_around(0, 0));
    check_cell(0, 0, board[0][0], "corner_no_wrap");
  endtask

  task automatic test_write_with_reveal();
    exp_t e;
    @(negedge clk);
    wEn[0] = 1'b1; addr1[0] = 5'd20; dataIn[0] = 32'd10;
    reveal_req[0] = 1'b1; reveal_id[0] = 5'd20;
    e.hit = 1'b1; e.safe = 3; e.lat = 2;
    sb.push_back(e);
    @(negedge clk);
    wEn[0] = 1'b0;
    reveal_req[0] = 1'b0;
    wait_done(0);
    board[0][20] = 32'd11;
    check_cell(0, 20, board[0][20], "write_then_reveal");
  endtask

  task automatic test_flood_full();
    for (int c = 0; c < N; c++) board[1][c] = 32'd9;
    board[1][24] = 32'd10;
    fill_board(1);
    issue(1, 0, 1'b0, 24, 0, 1);
    wait_done(1);
    for (int c = 0; c < N; c++) begin
      check_cell(1, c, (c == 24) ? 32'd10 : 32'(mines_around(1, c)), "flood_cell");
    end
    total++;
    if (q_overflow[1] !== 1'b0) begin
      bad++;
      $display("FAIL flood_no_overflow: got %b want 0", q_overflow[1]);
    end
  endtask

  task automatic test_overflow_busy_write();
    for (int c = 0; c < N; c++) board[2][c] = 32'd9;
    fill_board(2);
    issue(2, 12, 1'b0, -1, 0, 1);
    wEn[2] = 1'b1; addr1[2] = 5'd12; dataIn[2] = 32'hDEAD;
    wait_done(2);
    wEn[2] = 1'b0;
    total++;
    if (q_overflow[2] !== 1'b1) begin
      bad++;
      $display("FAIL overflow_sticky: got %b want 1", q_overflow[2]);
    end
    check_cell(2, 12, 32'd0, "busy_write_dropped");
  endtask

  task automatic test_reset_abort();
    int spurious = 0;
    issue(0, 18, 1'b0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (reveal_rdy[0] !== 1'b1 || safe_count[0] !== 5'd0) begin
      bad++;
      $display("FAIL abort_reset_state: rdy=%b safe=%0d want 1 0", reveal_rdy[0], safe_count[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (reveal_done[0] === 1'b1) spurious++;
    end
    total++;
    if (spurious != 0) begin
      bad++;
      $display("FAIL abort_no_done: got %0d pulses want 0", spurious);
    end
    check_cell(0, 18, 32'd9, "abort_cell_hidden");
    issue(0, 18, 1'b0, 1, 12, 1);
    wait_done(0);
    board[0][18] = 32'(mines_around(0, 18));
    check_cell(0, 18, board[0][18], "after_abort_reveal");
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      wEn[d] = 1'b0; addr1[d] = '0; dataIn[d] = '0; addr2[d] = '0;
      reveal_req[d] = 1'b0; reveal_id[d] = '0;
    end
    test_reset();
    test_single_reveal();
    test_mine_hit();
    test_already_revealed();
    test_edge_wrap();
    test_write_with_reveal();
    test_flood_full();
    test_overflow_busy_write();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
